// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux channel multiplexer: mode codes,
// scan state encoding and a select-width helper.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    SCAN_HOLD = 1'b0,
    SCAN_STEP = 1'b1
  } scan_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_mux_ctr.sv
// Dwell counter plus channel pointer for scan_mux; emits a registered wrap
// pulse on the edge where the pointer returns to channel 0.
module scan_mux_ctr
  import scan_mux_pkg::*;
#(
  parameter int CH    = 8,
  parameter int DWELL = 4,
  parameter int SW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [SW-1:0] load_val,
  output logic [SW-1:0] cur_sel,
  output logic          wrap
);

  localparam int CW = sel_width(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(CH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          wrap_q, wrap_d;
  scan_state_e   st;

  assign st = (cnt_q == CNT_LAST) ? SCAN_STEP : SCAN_HOLD;

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (load) begin
      sel_d = load_val;
      cnt_d = '0;
    end else if (en) begin
      case (st)
        SCAN_HOLD: cnt_d = cnt_q + 1'b1;
        SCAN_STEP: begin
          cnt_d = '0;
          // an out-of-range pointer (left over from manual mode) also wraps
          if (sel_q >= CH_LAST) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
    end
  end

  assign cur_sel = sel_q;
  assign wrap    = wrap_q;

endmodule

// File: rtl/scan_mux.sv
// N-channel W-bit registered mux with active-low enable and auto-scan.
// Define SCAN_MUX_HOLD_EN to hold y (instead of clearing) when disabled or sel invalid.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int CH    = 8,
  parameter  int W     = 4,
  parameter  int DWELL = 4,
  localparam int SW    = sel_width(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            g_l,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH*W-1:0] d,
  output logic [W-1:0]    y,
  output logic            y_valid,
  output logic [SW-1:0]   cur_sel,
  output logic            wrap
);

`ifdef SCAN_MUX_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  localparam int NSLOT = 2**SW;

  // Pad to a power of two so any select value indexes safely.
  logic [W-1:0]     chan [NSLOT];
  logic [NSLOT-1:0] ch_ok;

  for (genvar k = 0; k < NSLOT; k++) begin : g_chan
    if (k < CH) begin : g_real
      assign chan[k]  = d[k*W +: W];
      assign ch_ok[k] = 1'b1;
    end else begin : g_pad
      assign chan[k]  = '0;
      assign ch_ok[k] = 1'b0;
    end
  end

  logic          load, en;
  logic [SW-1:0] idx;
  logic [W-1:0]  y_q, y_d;
  logic          vld_q, vld_d;

  assign load = !g_l && (mode == MODE_MANUAL);
  assign en   = !g_l && (mode == MODE_SCAN);
  assign idx  = load ? sel : cur_sel;

  scan_mux_ctr #(
    .CH   (CH),
    .DWELL(DWELL),
    .SW   (SW)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(sel),
    .cur_sel (cur_sel),
    .wrap    (wrap)
  );

  always_comb begin
    y_d   = HOLD ? y_q : '0;
    vld_d = 1'b0;
    if (!g_l && ch_ok[idx]) begin
      y_d   = chan[idx];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y       = y_q;
  assign y_valid = vld_q;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: two instances (CH=8/DWELL=4, CH=5/DWELL=2)
// share stimulus; a countdown-dwell reference model feeds an expectation queue.
module tb_scan_mux;

`ifdef SCAN_MUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  localparam int CHN[2] = '{8, 5};
  localparam int DWN[2] = '{4, 2};

  typedef struct packed {
    logic [3:0] y;
    logic       v;
    logic [2:0] cs;
    logic       w;
  } obs_t;
  typedef obs_t [1:0] pair_t;

  logic        clk = 1'b0;
  logic        rst, g_l, mode;
  logic [2:0]  sel;
  logic [31:0] d;
  logic [3:0]  y_a, y_b;
  logic        vld_a, vld_b, wr_a, wr_b;
  logic [2:0]  cs_a, cs_b;

  always #5 clk = ~clk;

  scan_mux #(.CH(8), .W(4), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .g_l(g_l), .mode(mode), .sel(sel), .d(d),
    .y(y_a), .y_valid(vld_a), .cur_sel(cs_a), .wrap(wr_a));

  scan_mux #(.CH(5), .W(4), .DWELL(2)) u_b (
    .clk(clk), .rst(rst), .g_l(g_l), .mode(mode), .sel(sel), .d(d[19:0]),
    .y(y_b), .y_valid(vld_b), .cur_sel(cs_b), .wrap(wr_b));

  int    checks = 0;
  int    errors = 0;
  pair_t q[$];

  // Reference state: channel pointer and dwell cycles still left on it.
  int m_cur[2], m_left[2], m_y[2], m_v[2], m_w[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] chv(input int k);
    return d[k*4 +: 4];
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cur[i] = 0; m_left[i] = DWN[i]; m_y[i] = 0; m_v[i] = 0; m_w[i] = 0;
      end else if (g_l) begin
        if (!HOLD) m_y[i] = 0;
        m_v[i] = 0; m_w[i] = 0;
      end else if (mode == 1'b0) begin
        m_cur[i] = sel; m_left[i] = DWN[i]; m_w[i] = 0;
        if (int'(sel) < CHN[i]) begin m_y[i] = chv(sel); m_v[i] = 1; end
        else begin if (!HOLD) m_y[i] = 0; m_v[i] = 0; end
      end else begin
        if (m_cur[i] < CHN[i]) begin m_y[i] = chv(m_cur[i]); m_v[i] = 1; end
        else begin if (!HOLD) m_y[i] = 0; m_v[i] = 0; end
        m_w[i] = 0;
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_left[i] = DWN[i];
          if (m_cur[i] + 1 >= CHN[i]) begin m_cur[i] = 0; m_w[i] = 1; end
          else m_cur[i]++;
        end
      end
    end
  endtask

  function automatic obs_t mk(input int i);
    obs_t o;
    o.y = 4'(m_y[i]); o.v = m_v[i][0]; o.cs = 3'(m_cur[i]); o.w = m_w[i][0];
    return o;
  endfunction

  task automatic push_exp();
    pair_t e;
    e[0] = mk(0);
    e[1] = mk(1);
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic g, input logic m, input logic [2:0] s,
                     input logic [31:0] dd);
    @(negedge clk);
    rst = r; g_l = g; mode = m; sel = s; d = dd;
    model_step();
    push_exp();
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per edge.
  initial begin
    pair_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a.y",       {28'd0, y_a},  {28'd0, e[0].y});
        chk("a.y_valid", {31'd0, vld_a}, {31'd0, e[0].v});
        chk("a.cur_sel", {29'd0, cs_a}, {29'd0, e[0].cs});
        chk("a.wrap",    {31'd0, wr_a}, {31'd0, e[0].w});
        chk("b.y",       {28'd0, y_b},  {28'd0, e[1].y});
        chk("b.y_valid", {31'd0, vld_b}, {31'd0, e[1].v});
        chk("b.cur_sel", {29'd0, cs_b}, {29'd0, e[1].cs});
        chk("b.wrap",    {31'd0, wr_b}, {31'd0, e[1].w});
      end
    end
  end

  initial begin
    logic r, g, m;
    rst = 1'b1; g_l = 1'b1; mode = 1'b0; sel = '0; d = '0;
    cyc(1, 0, 0, 0, $urandom());
    cyc(1, 0, 1, 5, $urandom());
    // first manual select after reset
    cyc(0, 0, 0, 3, 32'h0000_A000);
    // manual sweep, d[k] = k+1
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 3'(k), 32'h8765_4321);
    // full scan from channel 0 with sel noise
    cyc(0, 0, 0, 0, $urandom());
    for (int k = 0; k < 40; k++) cyc(0, 0, 1, 3'($urandom_range(0, 7)), $urandom());
    // disable mid-scan at channel 5, counter 2
    cyc(0, 0, 0, 0, $urandom());
    for (int k = 0; k < 22; k++) cyc(0, 0, 1, 0, $urandom());
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, $urandom());
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, $urandom());
    // asynchronous reset between edges while scanning channel 6
    cyc(0, 0, 0, 6, $urandom());
    cyc(0, 0, 1, 0, $urandom());
    cyc(0, 0, 1, 0, $urandom());
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async.a.y",       {28'd0, y_a}, 32'd0);
    chk("async.a.y_valid", {31'd0, vld_a}, 32'd0);
    chk("async.a.cur_sel", {29'd0, cs_a}, 32'd0);
    chk("async.a.wrap",    {31'd0, wr_a}, 32'd0);
    chk("async.b.cur_sel", {29'd0, cs_b}, 32'd0);
    model_step();
    push_exp();
    for (int k = 0; k < 10; k++) cyc(0, 0, 1, 0, $urandom());
    // invalid then valid manual select on the CH=5 instance
    cyc(0, 0, 0, 6, $urandom());
    cyc(0, 0, 0, 4, $urandom());
    cyc(0, 0, 0, 7, $urandom());
    cyc(0, 1, 1, 2, $urandom());
    // randomized traffic with sticky mode
    m = 1'b1;
    for (int k = 0; k < 500; k++) begin
      r = ($urandom_range(0, 149) == 0);
      g = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) m = ~m;
      cyc(r, g, m, 3'($urandom_range(0, 7)), $urandom());
    end
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
